// File: rtl/text_console_writer_if.sv
// text_console_writer_if: character stream (valid/ready) and pixel-side read port
// of the text console buffer. The master drives characters and read addresses.
`default_nettype none

interface text_console_writer_if #(
  parameter int ROWS   = 15,
  parameter int COLS   = 40,
  parameter int CHAR_W = 8
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  logic              in_valid;
  logic [CHAR_W-1:0] in_char;
  logic              in_ready;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [CHAR_W-1:0] rd_char;

  modport master (output in_valid, in_char, rd_row, rd_col, input in_ready, rd_char);
  modport slave  (input in_valid, in_char, rd_row, rd_col, output in_ready, rd_char);
endinterface

`default_nettype wire

// File: rtl/text_console_writer.sv
// text_console_writer: ROWS x COLS text buffer with cursor, wrap and circular-row scroll.
// Optional macro CONSOLE_CURSOR_BLINK_EN adds a cursor blink counter (BLINK_CYCLES).
`default_nettype none

module text_console_writer #(
  parameter int ROWS   = 15,
  parameter int COLS   = 40,
  parameter int CHAR_W = 8
`ifdef CONSOLE_CURSOR_BLINK_EN
  , parameter int BLINK_CYCLES = 50_000_000
`endif
) (
  input  wire logic                     clk,
  input  wire logic                     reset_n,
  text_console_writer_if.slave          bus,
  output logic [$clog2(ROWS)-1:0]       o_cur_row,
  output logic [$clog2(COLS)-1:0]       o_cur_col,
  output logic                          o_cursor_on,
  output logic                          o_busy
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int A_W   = $clog2(ROWS * COLS);

  localparam logic [ROW_W-1:0]  c_ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  c_COL_MAX = COL_W'(COLS - 1);
  localparam logic [CHAR_W-1:0] c_SPACE   = CHAR_W'(8'h20);
  localparam logic [CHAR_W-1:0] c_TILDE   = CHAR_W'(8'h7E);
  localparam logic [CHAR_W-1:0] c_LF      = CHAR_W'(8'h0A);
  localparam logic [CHAR_W-1:0] c_CR      = CHAR_W'(8'h0D);
  localparam logic [CHAR_W-1:0] c_BS      = CHAR_W'(8'h08);
  localparam logic [CHAR_W-1:0] c_FF      = CHAR_W'(8'h0C);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_CLR_LINE   = 2'd1,
    S_CLR_SCREEN = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ROW_W-1:0]  r_top, w_top_nxt;
  logic [ROW_W-1:0]  r_cur_row, w_cur_row_nxt;
  logic [COL_W-1:0]  r_cur_col, w_cur_col_nxt;
  logic [ROW_W-1:0]  r_clr_row, w_clr_row_nxt;
  logic [COL_W-1:0]  r_clr_col, w_clr_col_nxt;
  logic              w_in_ready, w_accept, w_newline, w_we;
  logic [A_W-1:0]    w_waddr, w_raddr;
  logic [CHAR_W-1:0] w_wdata;
  logic              w_rd_oob;
  logic [CHAR_W-1:0] r_rd_char;
  logic [CHAR_W-1:0] r_mem [ROWS*COLS];

  // Logical to physical row, wrapping exactly at ROWS.
  function automatic logic [ROW_W-1:0] f_phys(input logic [ROW_W-1:0] lrow,
                                              input logic [ROW_W-1:0] top);
    logic [ROW_W:0] s;
    s = {1'b0, lrow} + {1'b0, top};
    if (s >= (ROW_W+1)'(ROWS)) s = s - (ROW_W+1)'(ROWS);
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [A_W-1:0] f_addr(input logic [ROW_W-1:0] prow,
                                            input logic [COL_W-1:0] col);
    return A_W'(prow) * A_W'(COLS) + A_W'(col);
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_top_nxt     = r_top;
    w_cur_row_nxt = r_cur_row;
    w_cur_col_nxt = r_cur_col;
    w_clr_row_nxt = r_clr_row;
    w_clr_col_nxt = r_clr_col;
    w_in_ready    = (r_state == S_IDLE);
    w_accept      = bus.in_valid && w_in_ready;
    w_newline     = 1'b0;
    w_we          = 1'b0;
    w_wdata       = c_SPACE;
    w_waddr       = f_addr(f_phys(r_cur_row, r_top), r_cur_col);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.in_char >= c_SPACE && bus.in_char <= c_TILDE) begin
            w_we    = 1'b1;
            w_wdata = bus.in_char;
            if (r_cur_col == c_COL_MAX) w_newline = 1'b1;
            else                        w_cur_col_nxt = r_cur_col + 1'b1;
          end else if (bus.in_char == c_LF || bus.in_char == c_CR) begin
            w_newline = 1'b1;
          end else if (bus.in_char == c_BS) begin
            if (r_cur_col != '0) begin
              w_cur_col_nxt = r_cur_col - 1'b1;
            end else if (r_cur_row != '0) begin
              w_cur_row_nxt = r_cur_row - 1'b1;
              w_cur_col_nxt = c_COL_MAX;
            end
            w_we    = 1'b1;
            w_waddr = f_addr(f_phys(w_cur_row_nxt, r_top), w_cur_col_nxt);
          end else if (bus.in_char == c_FF) begin
            w_top_nxt     = '0;
            w_cur_row_nxt = '0;
            w_cur_col_nxt = '0;
            w_clr_row_nxt = '0;
            w_clr_col_nxt = '0;
            w_state_nxt   = S_CLR_SCREEN;
          end

          if (w_newline) begin
            w_cur_col_nxt = '0;
            if (r_cur_row != c_ROW_MAX) begin
              w_cur_row_nxt = r_cur_row + 1'b1;
            end else begin
              // The new bottom row is physically the old top row.
              w_top_nxt     = (r_top == c_ROW_MAX) ? '0 : r_top + 1'b1;
              w_clr_row_nxt = r_top;
              w_clr_col_nxt = '0;
              w_state_nxt   = S_CLR_LINE;
            end
          end
        end
      end

      S_CLR_LINE: begin
        w_we    = 1'b1;
        w_waddr = f_addr(r_clr_row, r_clr_col);
        if (r_clr_col == c_COL_MAX) begin
          w_clr_col_nxt = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_clr_col_nxt = r_clr_col + 1'b1;
        end
      end

      S_CLR_SCREEN: begin
        w_we    = 1'b1;
        w_waddr = f_addr(r_clr_row, r_clr_col);
        if (r_clr_col == c_COL_MAX) begin
          w_clr_col_nxt = '0;
          if (r_clr_row == c_ROW_MAX) begin
            w_clr_row_nxt = '0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_clr_row_nxt = r_clr_row + 1'b1;
          end
        end else begin
          w_clr_col_nxt = r_clr_col + 1'b1;
        end
      end

      default: w_state_nxt = S_CLR_SCREEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_CLR_SCREEN;
      r_top     <= '0;
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_clr_row <= '0;
      r_clr_col <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_top     <= w_top_nxt;
      r_cur_row <= w_cur_row_nxt;
      r_cur_col <= w_cur_col_nxt;
      r_clr_row <= w_clr_row_nxt;
      r_clr_col <= w_clr_col_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign w_rd_oob = ({1'b0, bus.rd_row} >= (ROW_W+1)'(ROWS)) ||
                    ({1'b0, bus.rd_col} >= (COL_W+1)'(COLS));
  assign w_raddr  = f_addr(f_phys(bus.rd_row, r_top), bus.rd_col);

  // Same-cycle read of a cell being written sees the previous contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_rd_char <= '0;
    else if (w_rd_oob) r_rd_char <= c_SPACE;
    else               r_rd_char <= r_mem[w_raddr];
  end

`ifdef CONSOLE_CURSOR_BLINK_EN
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BL_W-1:0] r_blink_cnt;
  logic            r_cursor_on;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_cursor_on <= 1'b1;
    end else if (w_accept) begin
      r_blink_cnt <= '0;
      r_cursor_on <= 1'b1;
    end else if (r_blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_cursor_on <= ~r_cursor_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign o_cursor_on = r_cursor_on;
`else
  assign o_cursor_on = 1'b1;
`endif

  assign bus.in_ready = w_in_ready;
  assign bus.rd_char  = r_rd_char;
  assign o_busy       = ~w_in_ready;
  assign o_cur_row    = r_cur_row;
  assign o_cur_col    = r_cur_col;
endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed stimulus; read responses checked by a queue-based scoreboard.
`default_nettype none

module tb_text_console_writer;
  localparam int ROWS  = 15;
  localparam int COLS  = 40;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  typedef struct {
    string      nm;
    logic [7:0] exp;
  } sb_t;

  logic clk;
  logic reset_n;
  logic rd_issue;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic cursor_on;
  logic busy;
  int   n_vec;
  int   n_err;
  sb_t  sb[$];

  text_console_writer_if #(.ROWS(ROWS), .COLS(COLS), .CHAR_W(8)) bus ();

  text_console_writer #(
    .ROWS(ROWS), .COLS(COLS), .CHAR_W(8)
`ifdef CONSOLE_CURSOR_BLINK_EN
    , .BLINK_CYCLES(4)
`endif
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_cur_row   (cur_row),
    .o_cur_col   (cur_col),
    .o_cursor_on (cursor_on),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: rd_char is valid one cycle after the address was presented.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      if (rd_issue) begin
        #1;
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check(e.nm, int'(bus.rd_char), int'(e.exp));
        end
      end
    end
  end

  task automatic rd(input int r, input int c, input logic [7:0] exp, input string nm);
    bus.rd_row = ROW_W'(r);
    bus.rd_col = COL_W'(c);
    rd_issue   = 1'b1;
    sb.push_back('{nm, exp});
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    while (!bus.in_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic measure_busy(input int exp, input string nm);
    int n;
    n = 0;
    check({nm, "_busyflag"}, int'(busy), 1);
    while (!bus.in_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check(nm, n, exp);
  endtask

  task automatic chk_cur(input int r, input int c, input string nm);
    check({nm, "_row"}, int'(cur_row), r);
    check({nm, "_col"}, int'(cur_col), c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    rd_issue = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    bus.rd_row   = '0;
    bus.rd_col   = '0;

    // Reset state and power-up clear
    repeat (5) @(negedge clk);
    check("rst_rd_char", int'(bus.rd_char), 0);
    check("rst_ready", int'(bus.in_ready), 0);
    check("rst_cursor_on", int'(cursor_on), 1);
    chk_cur(0, 0, "rst_cur");
    reset_n = 1'b1;
    measure_busy(600, "init_clear_len");
    rd(0, 0, 8'h20, "init_00");
    rd(14, 39, 8'h20, "init_14_39");
    rd(7, 20, 8'h20, "init_7_20");

    // Single printable
    send(8'h41);
    rd(0, 0, 8'h41, "A_at_00");
    chk_cur(0, 1, "after_A");
    check("ready_after_A", int'(bus.in_ready), 1);

    // Form feed, then a full line with auto-wrap
    send(8'h0C);
    measure_busy(600, "ff_clear_len");
    chk_cur(0, 0, "after_ff");
    for (int i = 0; i < COLS; i++) send(8'h42);
    chk_cur(1, 0, "after_40B");
    rd(0, 39, 8'h42, "B_0_39");
    rd(1, 0, 8'h20, "blank_1_0");

    // Backspace across a line boundary and at home
    send(8'h08);
    chk_cur(0, 39, "bs_wrap");
    rd(0, 39, 8'h20, "bs_erased");
    rd(0, 38, 8'h42, "bs_kept");
    send(8'h0C);
    measure_busy(600, "ff2_clear_len");
    send(8'h08);
    chk_cur(0, 0, "bs_home");
    send(8'h01);
    chk_cur(0, 0, "ctrl_ignored");
    send(8'h0D);
    chk_cur(1, 0, "cr_newline");

    // Fill screen and scroll
    send(8'h0C);
    measure_busy(600, "ff3_clear_len");
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) send(8'(8'h30 + r));
    for (int c = 0; c < 5; c++) send(8'h3E);
    chk_cur(14, 5, "filled");
    send(8'h0A);
    measure_busy(40, "scroll_clear_len");
    chk_cur(14, 0, "after_scroll");
    rd(0, 0, 8'h31, "scr_0_0");
    rd(0, 39, 8'h31, "scr_0_39");
    rd(13, 4, 8'h3E, "scr_13_4");
    rd(13, 5, 8'h20, "scr_13_5");
    rd(14, 0, 8'h20, "scr_14_0");
    rd(14, 39, 8'h20, "scr_14_39");
    rd(15, 0, 8'h20, "oob_row");
    rd(0, 40, 8'h20, "oob_col");

    // Printable in the last cell scrolls again
    for (int c = 0; c < COLS; c++) send(8'h45);
    measure_busy(40, "lastcell_clear_len");
    chk_cur(14, 0, "after_lastcell");
    rd(13, 0, 8'h45, "lc_13_0");
    rd(13, 39, 8'h45, "lc_13_39");
    rd(12, 0, 8'h3E, "lc_12_0");
    rd(0, 0, 8'h32, "lc_0_0");
    rd(14, 20, 8'h20, "lc_14_20");

    // Form feed from (7,12)
    send(8'h0C);
    measure_busy(600, "ff4_clear_len");
    for (int i = 0; i < 7; i++) send(8'h0D);
    for (int i = 0; i < 12; i++) send(8'h58);
    chk_cur(7, 12, "at_7_12");
    send(8'h0C);
    measure_busy(600, "ff5_clear_len");
    chk_cur(0, 0, "after_ff5");
    rd(7, 0, 8'h20, "ff5_7_0");

    // Reset in the middle of a line clear
    for (int i = 0; i < ROWS; i++) send(8'h0A);
    repeat (10) @(negedge clk);
    check("midline_busy", int'(busy), 1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rd_char", int'(bus.rd_char), 0);
    chk_cur(0, 0, "midrst_cur");
    reset_n = 1'b1;
    measure_busy(600, "midrst_clear_len");
    rd(0, 0, 8'h20, "midrst_0_0");
    rd(14, 39, 8'h20, "midrst_14_39");

`ifdef CONSOLE_CURSOR_BLINK_EN
    send(8'h01);
    for (int k = 0; k < 16; k++) begin
      check("blink_phase", int'(cursor_on), ((k / 4) % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
    send(8'h01);
    check("blink_restart", int'(cursor_on), 1);
`else
    check("cursor_tied", int'(cursor_on), 1);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
